// File: rtl/m65c02_pkg.sv
// m65c02_pkg
// Shared encodings for the M65C02 adder writeback stage:
//   wsel_e  - destination register select (WSel)
//   cc_op_e - explicit flag operations (CC_Op)
//   P_*     - processor status bit positions
//   P_RST   - status register value at reset (I=1, B=1, bit5=1, D=0)
package m65c02_pkg;

    typedef enum logic [1:0] {
        WSEL_NONE = 2'd0,
        WSEL_A    = 2'd1,
        WSEL_X    = 2'd2,
        WSEL_Y    = 2'd3
    } wsel_e;

    typedef enum logic [2:0] {
        CC_NONE = 3'd0,
        CC_CLC  = 3'd1,
        CC_SEC  = 3'd2,
        CC_CLD  = 3'd3,
        CC_SED  = 3'd4,
        CC_CLI  = 3'd5,
        CC_SEI  = 3'd6,
        CC_CLV  = 3'd7
    } cc_op_e;

    localparam int unsigned P_N = 7;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_U = 5;
    localparam int unsigned P_B = 4;
    localparam int unsigned P_D = 3;
    localparam int unsigned P_I = 2;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_C = 0;

    localparam logic [7:0] P_RST = 8'h34;

endpackage

// File: rtl/m65c02_au_wb_if.sv
// m65c02_au_wb_if
// Bus between the adder/sequencer side (master) and the writeback stage (slave).
//   Rdy, Val, Sum[8:0], OV, WSel[1:0], FMsk[3:0], CC_Op[2:0], Ld_P, DI[7:0] : master -> slave
//   A, X, Y, P [7:0], CC, DM, Val_WB, Err                                  : slave -> master
interface m65c02_au_wb_if;
    logic       Rdy;
    logic       Val;
    logic [8:0] Sum;
    logic       OV;
    logic [1:0] WSel;
    logic [3:0] FMsk;
    logic [2:0] CC_Op;
    logic       Ld_P;
    logic [7:0] DI;
    logic [7:0] A;
    logic [7:0] X;
    logic [7:0] Y;
    logic [7:0] P;
    logic       CC;
    logic       DM;
    logic       Val_WB;
    logic       Err;

    modport master (
        output Rdy, Val, Sum, OV, WSel, FMsk, CC_Op, Ld_P, DI,
        input  A, X, Y, P, CC, DM, Val_WB, Err
    );

    modport slave (
        input  Rdy, Val, Sum, OV, WSel, FMsk, CC_Op, Ld_P, DI,
        output A, X, Y, P, CC, DM, Val_WB, Err
    );
endinterface

// File: rtl/m65c02_psw.sv
// m65c02_psw
// Processor status register P with its update priority, plus the sticky
// protocol error flag.
//   i_clk, i_rst (async, active-high)
//   i_rdy, i_val, i_sum[8:0], i_ov, i_wsel[1:0], i_fmsk[3:0], i_cc_op[2:0],
//   i_ld_p, i_di[7:0]
//   o_p[7:0] status {N,V,1,B,D,I,Z,C}, o_err sticky error
// Priority within one enabled cycle: Ld_P > CC_Op > FMsk adder update.
module m65c02_psw #(
    parameter logic [7:0] P_RST = m65c02_pkg::P_RST
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rdy,
    input  logic       i_val,
    input  logic [8:0] i_sum,
    input  logic       i_ov,
    input  logic [1:0] i_wsel,
    input  logic [3:0] i_fmsk,
    input  logic [2:0] i_cc_op,
    input  logic       i_ld_p,
    input  logic [7:0] i_di,
    output logic [7:0] o_p,
    output logic       o_err
);
    import m65c02_pkg::*;

    logic [7:0] r_p;
    logic [7:0] w_p_nxt;
    logic       r_err;
    logic       w_err_set;
    logic [3:0] w_cand;

    always_comb begin
        w_cand  = {i_sum[7], i_ov, (i_sum[7:0] == 8'h00), i_sum[8]};
        w_p_nxt = r_p;
        if (i_rdy) begin
            if (i_ld_p) begin
                w_p_nxt = i_di;
            end else begin
                if (i_val) begin
                    if (i_fmsk[3]) w_p_nxt[P_N] = w_cand[3];
                    if (i_fmsk[2]) w_p_nxt[P_V] = w_cand[2];
                    if (i_fmsk[1]) w_p_nxt[P_Z] = w_cand[1];
                    if (i_fmsk[0]) w_p_nxt[P_C] = w_cand[0];
                end
                // Applied after the adder update so it wins on a shared bit.
                case (cc_op_e'(i_cc_op))
                    CC_NONE: ;
                    CC_CLC:  w_p_nxt[P_C] = 1'b0;
                    CC_SEC:  w_p_nxt[P_C] = 1'b1;
                    CC_CLD:  w_p_nxt[P_D] = 1'b0;
                    CC_SED:  w_p_nxt[P_D] = 1'b1;
                    CC_CLI:  w_p_nxt[P_I] = 1'b0;
                    CC_SEI:  w_p_nxt[P_I] = 1'b1;
                    CC_CLV:  w_p_nxt[P_V] = 1'b0;
                endcase
            end
        end
        w_p_nxt[P_U] = 1'b1;
        w_p_nxt[P_B] = 1'b1;
    end

    assign w_err_set = i_rdy & ~i_val &
                       ((wsel_e'(i_wsel) != WSEL_NONE) | (i_fmsk != 4'h0));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p   <= P_RST;
            r_err <= 1'b0;
        end else begin
            r_p <= w_p_nxt;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_p   = r_p;
    assign o_err = r_err;

endmodule

// File: rtl/m65c02_au_wb.sv
// m65c02_au_wb
// Writeback/status stage after the M65C02 binary/decimal adder. Captures the
// adder result on Rdy & Val, writes it to A/X/Y, and maintains P.
//   Clk, Rst_Add (async, active-high)
//   bus : m65c02_au_wb_if.slave (adder inputs in; A/X/Y/P/CC/DM/Val_WB/Err out)
// CC and DM are taken straight from the P register to feed the adder.
module m65c02_au_wb #(
    parameter logic [7:0] P_RST = m65c02_pkg::P_RST
) (
    input  logic            Clk,
    input  logic            Rst_Add,
    m65c02_au_wb_if.slave   bus
);
    import m65c02_pkg::*;

    logic [7:0] r_a;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       r_val_wb;
    logic       w_cap;
    logic [7:0] w_p;
    logic       w_err;

    assign w_cap = bus.Rdy & bus.Val;

    always_ff @(posedge Clk or posedge Rst_Add) begin
        if (Rst_Add) begin
            r_a      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_val_wb <= 1'b0;
        end else begin
            r_val_wb <= w_cap;
            if (w_cap) begin
                case (wsel_e'(bus.WSel))
                    WSEL_NONE: ;
                    WSEL_A:    r_a <= bus.Sum[7:0];
                    WSEL_X:    r_x <= bus.Sum[7:0];
                    WSEL_Y:    r_y <= bus.Sum[7:0];
                endcase
            end
        end
    end

    m65c02_psw #(
        .P_RST (P_RST)
    ) u_psw (
        .i_clk   (Clk),
        .i_rst   (Rst_Add),
        .i_rdy   (bus.Rdy),
        .i_val   (bus.Val),
        .i_sum   (bus.Sum),
        .i_ov    (bus.OV),
        .i_wsel  (bus.WSel),
        .i_fmsk  (bus.FMsk),
        .i_cc_op (bus.CC_Op),
        .i_ld_p  (bus.Ld_P),
        .i_di    (bus.DI),
        .o_p     (w_p),
        .o_err   (w_err)
    );

    assign bus.A      = r_a;
    assign bus.X      = r_x;
    assign bus.Y      = r_y;
    assign bus.P      = w_p;
    assign bus.CC     = w_p[P_C];
    assign bus.DM     = w_p[P_D];
    assign bus.Val_WB = r_val_wb;
    assign bus.Err    = w_err;

endmodule

// File: tb/tb_m65c02_au_wb.sv
// tb_m65c02_au_wb
// Directed vector table for the documented scenarios, hand-written reset
// sequences, then a randomized phase checked against a behavioural model.
module tb_m65c02_au_wb;

    logic Clk;
    logic Rst_Add;

    m65c02_au_wb_if bus ();

    m65c02_au_wb #(
        .P_RST (8'h34)
    ) dut (
        .Clk     (Clk),
        .Rst_Add (Rst_Add),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk;
    int n_err;

    // Behavioural model state
    logic [7:0] m_a, m_x, m_y, m_p;
    logic       m_vwb, m_err;

    typedef struct {
        logic       rdy;
        logic       val;
        logic [8:0] sum;
        logic       ov;
        logic [1:0] wsel;
        logic [3:0] fmsk;
        logic [2:0] ccop;
        logic       ldp;
        logic [7:0] di;
        logic [7:0] ea, ex, ey, ep;
        logic       evwb, eerr;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic rdy, input logic val, input logic [8:0] sum,
                                input logic ov, input logic [1:0] wsel, input logic [3:0] fmsk,
                                input logic [2:0] ccop, input logic ldp, input logic [7:0] di,
                                input logic [7:0] ea, input logic [7:0] ex, input logic [7:0] ey,
                                input logic [7:0] ep, input logic evwb, input logic eerr);
        vec_t v;
        v.rdy = rdy; v.val = val; v.sum = sum; v.ov = ov; v.wsel = wsel; v.fmsk = fmsk;
        v.ccop = ccop; v.ldp = ldp; v.di = di;
        v.ea = ea; v.ex = ex; v.ey = ey; v.ep = ep; v.evwb = evwb; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] ex,
                           input logic [7:0] ey, input logic [7:0] ep, input logic evwb,
                           input logic eerr);
        chk({tag, ".A"},      bus.A, ea);
        chk({tag, ".X"},      bus.X, ex);
        chk({tag, ".Y"},      bus.Y, ey);
        chk({tag, ".P"},      bus.P, ep);
        chk({tag, ".CC"},     {7'd0, bus.CC}, {7'd0, ep[0]});
        chk({tag, ".DM"},     {7'd0, bus.DM}, {7'd0, ep[3]});
        chk({tag, ".Val_WB"}, {7'd0, bus.Val_WB}, {7'd0, evwb});
        chk({tag, ".Err"},    {7'd0, bus.Err}, {7'd0, eerr});
    endtask

    task automatic drive(input logic rdy, input logic val, input logic [8:0] sum,
                         input logic ov, input logic [1:0] wsel, input logic [3:0] fmsk,
                         input logic [2:0] ccop, input logic ldp, input logic [7:0] di);
        bus.Rdy = rdy; bus.Val = val; bus.Sum = sum; bus.OV = ov; bus.WSel = wsel;
        bus.FMsk = fmsk; bus.CC_Op = ccop; bus.Ld_P = ldp; bus.DI = di;
    endtask

    task automatic model_reset();
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h34; m_vwb = 1'b0; m_err = 1'b0;
    endtask

    // One rising edge of the documented behaviour, from the current bus inputs.
    task automatic model_step();
        logic n, v, z, c, d, i;
        logic captured;
        captured = bus.Rdy && bus.Val;
        m_vwb = captured;
        if (!bus.Rdy) return;
        if (captured) begin
            if (bus.WSel == 2'd1) m_a = bus.Sum[7:0];
            if (bus.WSel == 2'd2) m_x = bus.Sum[7:0];
            if (bus.WSel == 2'd3) m_y = bus.Sum[7:0];
        end else if (bus.WSel != 2'd0 || bus.FMsk != 4'd0) begin
            m_err = 1'b1;
        end
        if (bus.Ld_P) begin
            m_p = bus.DI | 8'h30;
            return;
        end
        n = m_p[7]; v = m_p[6]; d = m_p[3]; i = m_p[2]; z = m_p[1]; c = m_p[0];
        if (captured) begin
            if (bus.FMsk[3]) n = bus.Sum[7];
            if (bus.FMsk[2]) v = bus.OV;
            if (bus.FMsk[1]) z = (bus.Sum[7:0] == 0);
            if (bus.FMsk[0]) c = bus.Sum[8];
        end
        if (bus.CC_Op == 3'd1) c = 0;
        if (bus.CC_Op == 3'd2) c = 1;
        if (bus.CC_Op == 3'd3) d = 0;
        if (bus.CC_Op == 3'd4) d = 1;
        if (bus.CC_Op == 3'd5) i = 0;
        if (bus.CC_Op == 3'd6) i = 1;
        if (bus.CC_Op == 3'd7) v = 0;
        m_p = {n, v, 2'b11, d, i, z, c};
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // rdy val sum ov wsel fmsk ccop ldp di | A X Y P vwb err
        vt[0]  = mk(1,1,9'h100,1,1,4'hF,0,0,8'h00, 8'h00,8'h00,8'h00,8'h77,1,0); // overflow add
        vt[1]  = mk(1,0,9'h000,0,0,4'h0,0,0,8'h00, 8'h00,8'h00,8'h00,8'h77,0,0); // idle
        vt[2]  = mk(1,1,9'h1FF,0,1,4'hF,1,0,8'h00, 8'hFF,8'h00,8'h00,8'hB4,1,0); // CLC beats C
        vt[3]  = mk(1,1,9'h1FF,0,1,4'hF,1,1,8'h00, 8'hFF,8'h00,8'h00,8'h30,1,0); // Ld_P wins
        vt[4]  = mk(1,0,9'h000,0,0,4'h0,4,0,8'h00, 8'hFF,8'h00,8'h00,8'h38,0,0); // SED
        vt[5]  = mk(1,0,9'h000,0,0,4'h0,6,0,8'h00, 8'hFF,8'h00,8'h00,8'h3C,0,0); // SEI
        vt[6]  = mk(1,1,9'h100,0,2,4'hB,0,0,8'h00, 8'hFF,8'h00,8'h00,8'h3F,1,0); // decimal 99+01
        vt[7]  = mk(0,1,9'h055,0,3,4'hF,0,0,8'h00, 8'hFF,8'h00,8'h00,8'h3F,0,0); // stall
        vt[8]  = mk(1,1,9'h055,0,3,4'hF,0,0,8'h00, 8'hFF,8'h00,8'h55,8'h3C,1,0); // release
        vt[9]  = mk(1,1,9'h080,1,0,4'hF,7,0,8'h00, 8'hFF,8'h00,8'h55,8'hBC,1,0); // CLV beats V
        vt[10] = mk(1,0,9'h000,0,0,4'h0,3,0,8'h00, 8'hFF,8'h00,8'h55,8'hB4,0,0); // CLD
        vt[11] = mk(1,0,9'h000,0,0,4'h0,5,0,8'h00, 8'hFF,8'h00,8'h55,8'hB0,0,0); // CLI
        vt[12] = mk(1,0,9'h000,0,0,4'h0,2,0,8'h00, 8'hFF,8'h00,8'h55,8'hB1,0,0); // SEC
        vt[13] = mk(1,0,9'h0AA,0,1,4'h0,0,0,8'h00, 8'hFF,8'h00,8'h55,8'hB1,0,1); // error
        vt[14] = mk(1,0,9'h000,0,0,4'h0,0,0,8'h00, 8'hFF,8'h00,8'h55,8'hB1,0,1); // sticky

        drive(0,0,9'h000,0,0,4'h0,0,0,8'h00);
        Rst_Add = 1'b1;
        #3;
        chk_all("rst_init", 8'h00, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0);
        @(negedge Clk);
        Rst_Add = 1'b0;

        for (int k = 0; k < 15; k++) begin
            @(negedge Clk);
            drive(vt[k].rdy, vt[k].val, vt[k].sum, vt[k].ov, vt[k].wsel, vt[k].fmsk,
                  vt[k].ccop, vt[k].ldp, vt[k].di);
            @(posedge Clk);
            #1;
            chk_all($sformatf("vec%0d", k), vt[k].ea, vt[k].ex, vt[k].ey, vt[k].ep,
                    vt[k].evwb, vt[k].eerr);
        end

        // Mid-cycle reset pulse: outputs return to reset values with no edge.
        @(negedge Clk);
        drive(1,0,9'h000,0,0,4'h0,0,0,8'h00);
        #2 Rst_Add = 1'b1;
        #1;
        chk_all("rst_mid", 8'h00, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0);
        Rst_Add = 1'b0;

        // Result presented on the same edge as reset is discarded.
        @(negedge Clk);
        drive(1,1,9'h142,0,2,4'hF,0,0,8'h00);
        #3 Rst_Add = 1'b1;
        @(posedge Clk);
        #1;
        chk_all("rst_edge", 8'h00, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0);
        @(negedge Clk);
        drive(1,0,9'h000,0,0,4'h0,0,0,8'h00);
        Rst_Add = 1'b0;

        // Randomized phase against the model; a reset now and then re-arms Err.
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            if ((c % 100) == 99) begin
                Rst_Add = 1'b1;
                #1;
                model_reset();
                chk_all("rnd_rst", m_a, m_x, m_y, m_p, m_vwb, m_err);
                Rst_Add = 1'b0;
            end
            drive(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 5) != 0),
                  9'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                  ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)));
            model_step();
            @(posedge Clk);
            #1;
            chk_all("rnd", m_a, m_x, m_y, m_p, m_vwb, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/m65c02_au_wb.md
# m65c02_au_wb

Writeback and status stage directly downstream of the M65C02 binary/decimal adder. It samples the adder's 9-bit result, overflow and valid outputs on the rising clock edge. It writes the 8-bit result into A, X or Y and updates the N, V, Z and C flags of the processor status register P. It also supplies the registered carry and decimal-mode bits that feed back into the adder's `Ci` and `En_DU` selection.

## Interface
Parameters:
- `P_RST`, default 8'h34: P value at reset (I=1, B=1, bit5=1, D=0).

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst_Add`  in  1  reset, asynchronous, active-high.
- `Rdy`  in  1  cycle enable; low means every register holds.
- `Val`  in  1  adder result valid.
- `Sum`  in  9  adder result: {Co, R[7:0]}.
- `OV`  in  1  adder overflow.
- `WSel`  in  2  destination: 0 none, 1 A, 2 X, 3 Y.
- `FMsk`  in  4  flag update mask {N,V,Z,C}; 1 means the flag takes the adder-derived value.
- `CC_Op`  in  3  flag op: 0 none, 1 CLC, 2 SEC, 3 CLD, 4 SED, 5 CLI, 6 SEI, 7 CLV.
- `Ld_P`  in  1  load P from `DI` (PLP/RTI).
- `DI`  in  8  P load data.
- `A`, `X`, `Y`  out  8  registers, each 8'h00 at reset.
- `P`  out  8  status {N,V,1,B,D,I,Z,C}; `P_RST` at reset.
- `CC`  out  1  P[0], to adder `Ci`.
- `DM`  out  1  P[3], decimal-mode select for `En_DU`.
- `Val_WB`  out  1  registered writeback strobe; 0 at reset.
- `Err`  out  1  sticky protocol error; 0 at reset.

## Operation
- Capture condition: `Rdy & Val` at the rising edge.
  - Write `Sum[7:0]` to the register selected by `WSel`.
  - Then compute flag candidates: N=`Sum[7]`, V=`OV`, Z=(`Sum[7:0]`==0), C=`Sum[8]`.
  - Each P bit whose `FMsk` bit is set takes its candidate value.
  - In decimal mode Z and N come from the adjusted BCD result, because that is what arrives on `Sum`.
- `CC_Op` is applied when `Rdy` is high and does not depend on `Val`.
  - It modifies only its target bit.
  - If an adder update in the same cycle touches the same bit, the `CC_Op` result wins (CLV with FMsk.V=1 leaves V=0).
- `Ld_P` with `Rdy` high sets P = `DI | 8'h30`, forcing bit5 and B to 1.
  - `Ld_P` overrides both `FMsk` and `CC_Op` for all P bits in that cycle.
  - Register writeback selected by `WSel` still occurs.
- P bit5 and bit4 read 1 at all times and are never written 0.
- `Val` low: no register write, no `FMsk` flag update.
  - If `Rdy` is high and (`WSel`!=0 or `FMsk`!=0), set `Err`.
  - `Err` clears only on `Rst_Add`.
- `Rdy` low: A, X, Y, P and `Err` hold, and `Val_WB` is driven to 0 on the next edge.
- `Val_WB` is registered `Rdy & Val`: one cycle high per captured result.
- Arithmetic: none beyond the zero detect. `Sum` passes through unmodified; no width extension.

## Timing
- The adder's pipeline registers update on the falling edge, so `Sum`/`OV`/`Val` are stable for the second half-cycle. This block samples them on the following rising edge.
- Latency: new A/X/Y/P/`CC`/`DM` are visible one rising edge after capture; `Val_WB` asserts in the same cycle as the new values.
- `CC` and `DM` are direct register outputs, with no combinational path from any input. An operation issued on the cycle after a flag change therefore sees the updated carry and decimal mode.
- Back-to-back `Val` every cycle is supported with no bubbles.
- `Rst_Add` asserted mid-cycle: all outputs go to reset values immediately, with no clock needed. Deassertion is synchronised by the team's reset scheme upstream.
- `Rst_Add` asserted on the same edge as `Val`: reset wins and the result is discarded.

## Structure
- Shared package `m65c02_pkg`:
  - `WSel` encodings.
  - `CC_Op` encodings.
  - P bit index constants (N=7, V=6, B=4, D=3, I=2, Z=1, C=0).
  - `P_RST`.
- One natural sub-module: `m65c02_psw`, the P register with `FMsk`/`CC_Op`/`Ld_P` priority logic and the sticky `Err` flag.
- The top level holds A/X/Y writeback and `Val_WB`.

## Test plan
- Reset: pulse `Rst_Add` between clock edges -> immediately A=X=Y=00, P=34, `CC`=0, `DM`=0, `Val_WB`=0, `Err`=0.
- Binary add overflow: `Val`=1, `Sum`=9'h100, `OV`=1, `WSel`=A, `FMsk`=1111 -> next edge A=00, P=77, `CC`=1, `Val_WB`=1 for one cycle.
- Flag priority: `Sum`=9'h1FF, `FMsk`=1111, `CC_Op`=CLC -> P has N=1, C=0 (P=B4). Repeating the stimulus with `Ld_P`=1, `DI`=00 gives P=30, with A still written FF.
- Decimal path: `CC_Op`=SED, then `Val`=1, `Sum`=9'h100 (99+01 BCD), `WSel`=X, `FMsk`=1011 -> `DM`=1, X=00, P=3F.
- Stall: `Rdy`=0 with `Val`=1, `Sum`=9'h055, `WSel`=Y -> Y, P unchanged, `Val_WB`=0. Raising `Rdy` on the next cycle gives Y=55.
- Error: `Rdy`=1, `Val`=0, `WSel`=A -> A holds, `Err`=1 and stays 1 until `Rst_Add`.
